// File: rtl/nibble_pair_sequencer.sv
// nibble_pair_sequencer
// Loads two nibbles over a valid/ready handshake, then steps the select line
// of a downstream 2:1 selector through DWELL-cycle phases (s=0, then s=1),
// REPEAT times, before returning to loading.
// All outputs come from the state register and counters only.
module nibble_pair_sequencer #(
    parameter int W      = 4,
    parameter int DWELL  = 4,
    parameter int REPEAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic [W-1:0] d0,
    output logic [W-1:0] d1,
    output logic         s,
    output logic         out_valid,
    output logic         done
);

    typedef enum logic [1:0] {
        LOAD0 = 2'd0,
        LOAD1 = 2'd1,
        SHOW0 = 2'd2,
        SHOW1 = 2'd3
    } state_t;

    // Terminal counts; the compares stop both counters before they could wrap.
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [7:0] REP_LAST   = 8'(REPEAT - 1);

    state_t     state;
    logic [7:0] dwell_cnt;
    logic [7:0] rep_cnt;

    // Sequencer: handshake capture of d0/d1, then dwell/repeat pattern; flush aborts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD0;
            d0        <= '0;
            d1        <= '0;
            dwell_cnt <= '0;
            rep_cnt   <= '0;
        end else if (flush) begin
            // Abort discards any coinciding accept; d0/d1 keep their values.
            state     <= LOAD0;
            dwell_cnt <= '0;
            rep_cnt   <= '0;
        end else begin
            case (state)
                LOAD0: begin
                    if (in_valid && in_ready) begin
                        d0    <= in_data;
                        state <= LOAD1;
                    end
                end
                LOAD1: begin
                    if (in_valid && in_ready) begin
                        d1        <= in_data;
                        dwell_cnt <= '0;
                        rep_cnt   <= '0;
                        state     <= SHOW0;
                    end
                end
                SHOW0: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                        state     <= SHOW1;
                    end else begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end
                end
                SHOW1: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                        if (rep_cnt == REP_LAST) begin
                            rep_cnt <= '0;
                            state   <= LOAD0;
                        end else begin
                            rep_cnt <= rep_cnt + 8'd1;
                            state   <= SHOW0;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end
                end
                default: state <= LOAD0;
            endcase
        end
    end

    // Output decode from registered state and counters only.
    always_comb begin
        in_ready  = (state == LOAD0) || (state == LOAD1);
        out_valid = (state == SHOW0) || (state == SHOW1);
        s         = (state == SHOW1);
        done      = (state == SHOW1) && (dwell_cnt == DWELL_LAST) && (rep_cnt == REP_LAST);
    end

endmodule
